// File: rtl/pointwise_layer_sched_if.sv
// Bus bundle between the pointwise-layer scheduler and its surroundings:
// weight stream, weight write port, feature gating and output monitor.
interface pointwise_layer_sched_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned AW     = 11
);
    logic [DATA_W-1:0] w_tdata;
    logic              w_tvalid;
    logic              w_tready;
    logic              pw_wr_en;
    logic [AW-1:0]     pw_wr_addr;
    logic [DATA_W-1:0] pw_wr_data;
    logic              up_tvalid;
    logic              up_tready;
    logic              lay_tvalid;
    logic              lay_tready;
    logic              out_tvalid;
    logic              out_tready;

    modport master (
        input  w_tdata, w_tvalid, up_tvalid, lay_tready, out_tvalid, out_tready,
        output w_tready, pw_wr_en, pw_wr_addr, pw_wr_data, up_tready, lay_tvalid
    );

    modport slave (
        output w_tdata, w_tvalid, up_tvalid, lay_tready, out_tvalid, out_tready,
        input  w_tready, pw_wr_en, pw_wr_addr, pw_wr_data, up_tready, lay_tvalid
    );
endinterface

// File: rtl/pointwise_layer_sched.sv
// Job sequencer for one pointwise 1x1 layer: optional weight load from a byte stream,
// then gates num_pixels feature beats in and counts output beats until completion.
module pointwise_layer_sched #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CIN    = 32,
    parameter int unsigned COUT   = 64,
    parameter int unsigned PIX_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   reload_w,
    input  logic [PIX_W-1:0]       num_pixels,
    input  logic                   intr_clr,
    pointwise_layer_sched_if.master bus,
    output logic                   busy,
    output logic                   done,
    output logic                   o_intr,
    output logic                   err,
    output logic [PIX_W-1:0]       pix_in_cnt,
    output logic [PIX_W-1:0]       pix_out_cnt
);
    localparam int unsigned NW = COUT * CIN;
    localparam int unsigned AW = $clog2(NW);
    localparam logic [AW:0] NW_CNT = (AW + 1)'(NW);
    localparam logic [AW:0] LAST_W = (AW + 1)'(NW - 1);

    typedef enum logic [1:0] {StIdle, StLoadW, StRun, StDone} state_e;

    state_e            r_state;
    logic [AW:0]       r_wr_cnt;
    logic [PIX_W-1:0]  r_num_pix;
    logic [PIX_W-1:0]  r_pix_in;
    logic [PIX_W-1:0]  r_pix_out;
    logic              r_pw_wr_en;
    logic [AW-1:0]     r_pw_wr_addr;
    logic [DATA_W-1:0] r_pw_wr_data;
    logic              r_done;
    logic              r_intr;
    logic              r_err;

    logic w_gate;
    logic w_w_hs;
    logic w_up_hs;
    logic w_out_hs;

    assign w_gate         = (r_state == StRun) && (r_pix_in < r_num_pix);
    assign bus.w_tready   = (r_state == StLoadW) && (r_wr_cnt < NW_CNT);
    assign bus.lay_tvalid = bus.up_tvalid & w_gate;
    assign bus.up_tready  = bus.lay_tready & w_gate;
    assign w_w_hs         = bus.w_tvalid & bus.w_tready;
    assign w_up_hs        = bus.up_tvalid & bus.up_tready;
    assign w_out_hs       = bus.out_tvalid & bus.out_tready;

    assign bus.pw_wr_en   = r_pw_wr_en;
    assign bus.pw_wr_addr = r_pw_wr_addr;
    assign bus.pw_wr_data = r_pw_wr_data;
    assign busy           = (r_state != StIdle);
    assign done           = r_done;
    assign o_intr         = r_intr;
    assign err            = r_err;
    assign pix_in_cnt     = r_pix_in;
    assign pix_out_cnt    = r_pix_out;

    // done and o_intr are raised on every transition into StDone, so done spans that state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= StIdle;
            r_wr_cnt     <= '0;
            r_num_pix    <= '0;
            r_pix_in     <= '0;
            r_pix_out    <= '0;
            r_pw_wr_en   <= 1'b0;
            r_pw_wr_addr <= '0;
            r_pw_wr_data <= '0;
            r_done       <= 1'b0;
            r_intr       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_pw_wr_en <= 1'b0;
            r_done     <= 1'b0;
            if (intr_clr) r_intr <= 1'b0;
            if (w_out_hs && (r_state != StRun)) r_err <= 1'b1;

            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_num_pix <= num_pixels;
                        r_pix_in  <= '0;
                        r_pix_out <= '0;
                        r_wr_cnt  <= '0;
                        r_err     <= 1'b0;
                        r_intr    <= 1'b0;
                        if (reload_w) begin
                            r_state <= StLoadW;
                        end else if (num_pixels != '0) begin
                            r_state <= StRun;
                        end else begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                            r_intr  <= 1'b1;
                        end
                    end
                end
                StLoadW: begin
                    if (w_w_hs) begin
                        r_pw_wr_en   <= 1'b1;
                        r_pw_wr_addr <= r_wr_cnt[AW-1:0];
                        r_pw_wr_data <= bus.w_tdata;
                        r_wr_cnt     <= r_wr_cnt + (AW + 1)'(1);
                        if (r_wr_cnt == LAST_W) begin
                            if (r_num_pix == '0) begin
                                r_state <= StDone;
                                r_done  <= 1'b1;
                                r_intr  <= 1'b1;
                            end else begin
                                r_state <= StRun;
                            end
                        end
                    end
                end
                StRun: begin
                    if (w_up_hs) r_pix_in <= r_pix_in + PIX_W'(1);
                    if (w_out_hs) begin
                        r_pix_out <= r_pix_out + PIX_W'(1);
                        if ((r_pix_out + PIX_W'(1)) == r_num_pix) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                            r_intr  <= 1'b1;
                        end
                    end
                end
                StDone:  r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_pointwise_layer_sched.sv
// Directed bench for pointwise_layer_sched: per-cycle vector table plus a mid-load reset.
module tb_pointwise_layer_sched;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        reload_w = 1'b0;
    logic [15:0] num_pixels = '0;
    logic        intr_clr = 1'b0;
    logic        busy, done, o_intr, err;
    logic [15:0] pix_in_cnt, pix_out_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pointwise_layer_sched_if #(.DATA_W(8), .AW(3)) bus ();

    pointwise_layer_sched #(
        .DATA_W(8), .CIN(2), .COUT(4), .PIX_W(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .reload_w   (reload_w),
        .num_pixels (num_pixels),
        .intr_clr   (intr_clr),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .o_intr     (o_intr),
        .err        (err),
        .pix_in_cnt (pix_in_cnt),
        .pix_out_cnt(pix_out_cnt)
    );

    always #5 clk = ~clk;

    // Inputs applied during a cycle, and outputs expected in that same cycle.
    typedef struct {
        int st; int rl; int np; int ic; int wv; int wd; int uv; int lr; int ov; int ordy;
        int wr; int we; int wa; int wdt; int lv; int ur; int bz; int dn; int in; int er;
        int pi; int po;
    } vec_t;

    vec_t vecs[30];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        start = 1'b0; reload_w = 1'b0; num_pixels = '0; intr_clr = 1'b0;
        bus.w_tvalid = 1'b0; bus.w_tdata = '0; bus.up_tvalid = 1'b0;
        bus.lay_tready = 1'b0; bus.out_tvalid = 1'b0; bus.out_tready = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " o_intr"}, 32'(o_intr), 0);
        chk({tag, " err"}, 32'(err), 0);
        chk({tag, " pw_wr_en"}, 32'(bus.pw_wr_en), 0);
        chk({tag, " pw_wr_addr"}, 32'(bus.pw_wr_addr), 0);
        chk({tag, " pw_wr_data"}, 32'(bus.pw_wr_data), 0);
        chk({tag, " w_tready"}, 32'(bus.w_tready), 0);
        chk({tag, " pix_in_cnt"}, 32'(pix_in_cnt), 0);
        chk({tag, " pix_out_cnt"}, 32'(pix_out_cnt), 0);
    endtask

    initial begin
        bit found;
        //          st rl np ic  wv wd    uv lr ov or   wr we wa wdt   lv ur bz dn in er  pi po
        vecs[0]  = '{0, 0, 0, 0,  0, 0,    0, 0, 1, 1,   0, 0, 0, 0,    0, 0, 0, 0, 0, 0,  0, 0};
        vecs[1]  = '{0, 0, 0, 0,  0, 0,    0, 0, 0, 0,   0, 0, 0, 0,    0, 0, 0, 0, 0, 1,  0, 0};
        vecs[2]  = '{1, 1, 3, 0,  0, 0,    0, 0, 0, 0,   0, 0, 0, 0,    0, 0, 0, 0, 0, 1,  0, 0};
        vecs[3]  = '{0, 0, 0, 0,  1, 'h11, 0, 0, 0, 0,   1, 0, 0, 0,    0, 0, 1, 0, 0, 0,  0, 0};
        vecs[4]  = '{0, 0, 0, 0,  1, 'h22, 0, 0, 0, 0,   1, 1, 0, 'h11, 0, 0, 1, 0, 0, 0,  0, 0};
        vecs[5]  = '{0, 0, 0, 0,  0, 0,    0, 0, 0, 0,   1, 1, 1, 'h22, 0, 0, 1, 0, 0, 0,  0, 0};
        vecs[6]  = '{1, 0, 0, 0,  0, 0,    0, 0, 0, 0,   1, 0, 0, 0,    0, 0, 1, 0, 0, 0,  0, 0};
        vecs[7]  = '{0, 0, 0, 0,  1, 'h33, 0, 0, 0, 0,   1, 0, 0, 0,    0, 0, 1, 0, 0, 0,  0, 0};
        vecs[8]  = '{0, 0, 0, 0,  1, 'h44, 0, 0, 0, 0,   1, 1, 2, 'h33, 0, 0, 1, 0, 0, 0,  0, 0};
        vecs[9]  = '{0, 0, 0, 0,  1, 'h55, 0, 0, 0, 0,   1, 1, 3, 'h44, 0, 0, 1, 0, 0, 0,  0, 0};
        vecs[10] = '{0, 0, 0, 0,  1, 'h66, 0, 0, 0, 0,   1, 1, 4, 'h55, 0, 0, 1, 0, 0, 0,  0, 0};
        vecs[11] = '{0, 0, 0, 0,  1, 'h77, 0, 0, 0, 0,   1, 1, 5, 'h66, 0, 0, 1, 0, 0, 0,  0, 0};
        vecs[12] = '{0, 0, 0, 0,  1, 'h88, 0, 0, 0, 0,   1, 1, 6, 'h77, 0, 0, 1, 0, 0, 0,  0, 0};
        vecs[13] = '{0, 0, 0, 0,  1, 'h99, 0, 0, 0, 0,   0, 1, 7, 'h88, 0, 0, 1, 0, 0, 0,  0, 0};
        vecs[14] = '{0, 0, 0, 0,  0, 0,    1, 1, 0, 0,   0, 0, 0, 0,    1, 1, 1, 0, 0, 0,  0, 0};
        vecs[15] = '{0, 0, 0, 0,  0, 0,    1, 0, 0, 0,   0, 0, 0, 0,    1, 0, 1, 0, 0, 0,  1, 0};
        vecs[16] = '{0, 0, 0, 0,  0, 0,    1, 1, 1, 1,   0, 0, 0, 0,    1, 1, 1, 0, 0, 0,  1, 0};
        vecs[17] = '{0, 0, 0, 0,  0, 0,    1, 1, 1, 0,   0, 0, 0, 0,    1, 1, 1, 0, 0, 0,  2, 1};
        vecs[18] = '{0, 0, 0, 0,  0, 0,    1, 1, 1, 1,   0, 0, 0, 0,    0, 0, 1, 0, 0, 0,  3, 1};
        vecs[19] = '{1, 1, 5, 0,  0, 0,    1, 1, 1, 1,   0, 0, 0, 0,    0, 0, 1, 0, 0, 0,  3, 2};
        vecs[20] = '{1, 0, 0, 0,  0, 0,    1, 1, 0, 0,   0, 0, 0, 0,    0, 0, 1, 1, 1, 0,  3, 3};
        vecs[21] = '{0, 0, 0, 0,  0, 0,    0, 0, 0, 0,   0, 0, 0, 0,    0, 0, 0, 0, 1, 0,  3, 3};
        vecs[22] = '{0, 0, 0, 1,  0, 0,    0, 0, 0, 0,   0, 0, 0, 0,    0, 0, 0, 0, 1, 0,  3, 3};
        vecs[23] = '{1, 0, 0, 1,  0, 0,    1, 1, 0, 0,   0, 0, 0, 0,    0, 0, 0, 0, 0, 0,  3, 3};
        vecs[24] = '{0, 0, 0, 0,  0, 0,    1, 1, 0, 0,   0, 0, 0, 0,    0, 0, 1, 1, 1, 0,  0, 0};
        vecs[25] = '{0, 0, 0, 0,  0, 0,    0, 0, 1, 1,   0, 0, 0, 0,    0, 0, 0, 0, 1, 0,  0, 0};
        vecs[26] = '{1, 0, 1, 0,  0, 0,    0, 0, 0, 0,   0, 0, 0, 0,    0, 0, 0, 0, 1, 1,  0, 0};
        vecs[27] = '{0, 0, 0, 0,  0, 0,    1, 1, 1, 1,   0, 0, 0, 0,    1, 1, 1, 0, 0, 0,  0, 0};
        vecs[28] = '{0, 0, 0, 0,  0, 0,    1, 1, 0, 0,   0, 0, 0, 0,    0, 0, 1, 1, 1, 0,  1, 1};
        vecs[29] = '{0, 0, 0, 0,  0, 0,    0, 0, 0, 0,   0, 0, 0, 0,    0, 0, 0, 0, 1, 0,  1, 1};

        idle_inputs();
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_all_zero("post-reset");

        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            start          = 1'(vecs[i].st);
            reload_w       = 1'(vecs[i].rl);
            num_pixels     = 16'(vecs[i].np);
            intr_clr       = 1'(vecs[i].ic);
            bus.w_tvalid   = 1'(vecs[i].wv);
            bus.w_tdata    = 8'(vecs[i].wd);
            bus.up_tvalid  = 1'(vecs[i].uv);
            bus.lay_tready = 1'(vecs[i].lr);
            bus.out_tvalid = 1'(vecs[i].ov);
            bus.out_tready = 1'(vecs[i].ordy);
            #1;
            chk($sformatf("v%0d w_tready", i), 32'(bus.w_tready), vecs[i].wr);
            chk($sformatf("v%0d pw_wr_en", i), 32'(bus.pw_wr_en), vecs[i].we);
            if (vecs[i].we != 0) begin
                chk($sformatf("v%0d pw_wr_addr", i), 32'(bus.pw_wr_addr), vecs[i].wa);
                chk($sformatf("v%0d pw_wr_data", i), 32'(bus.pw_wr_data), vecs[i].wdt);
            end
            chk($sformatf("v%0d lay_tvalid", i), 32'(bus.lay_tvalid), vecs[i].lv);
            chk($sformatf("v%0d up_tready", i), 32'(bus.up_tready), vecs[i].ur);
            chk($sformatf("v%0d busy", i), 32'(busy), vecs[i].bz);
            chk($sformatf("v%0d done", i), 32'(done), vecs[i].dn);
            chk($sformatf("v%0d o_intr", i), 32'(o_intr), vecs[i].in);
            chk($sformatf("v%0d err", i), 32'(err), vecs[i].er);
            chk($sformatf("v%0d pix_in_cnt", i), 32'(pix_in_cnt), vecs[i].pi);
            chk($sformatf("v%0d pix_out_cnt", i), 32'(pix_out_cnt), vecs[i].po);
        end

        // Reset asserted while the load has just written address 5.
        @(negedge clk);
        idle_inputs();
        start = 1'b1; reload_w = 1'b1; num_pixels = 16'd2;
        @(negedge clk);
        idle_inputs();
        bus.w_tvalid = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            bus.w_tdata = 8'(8'hA0 + k);
            @(negedge clk);
            #1;
            if (bus.pw_wr_en && bus.pw_wr_addr == 3'd5) found = 1'b1;
        end
        chk("reached addr 5", 32'(found), 1);
        chk("addr 5 data", 32'(bus.pw_wr_data), 32'h0A5);
        reset = 1'b0;
        #1;
        chk_all_zero("mid-load reset");
        bus.w_tvalid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_all_zero("after mid-load reset");
        start = 1'b1; num_pixels = 16'd1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("restart busy", 32'(busy), 1);
        chk("restart lay_tvalid gated", 32'(bus.lay_tvalid), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
